// File: rtl/alu_pkg.sv
// Shared ALU types: data width, op encoding and the test-vector record.
package alu_pkg;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned IDX_W       = $clog2(NUM_VECTORS);

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_SHL    = 3'd5,
        OP_SHR    = 3'd6,
        OP_PASS_B = 3'd7
    } alu_op_t;

    typedef struct packed {
        alu_op_t          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
        logic             c;
    } alu_vec_t;

endpackage

// File: rtl/alu_self_test_if.sv
// Status/control bundle between the ALU self-test harness and its environment.
interface alu_self_test_if;
    import alu_pkg::*;

    logic             force_error;
    logic             result_out;
    logic             done;
    logic [IDX_W-1:0] fail_index;

    modport master (output force_error, input result_out, input done, input fail_index);
    modport slave  (input force_error, output result_out, output done, output fail_index);
endinterface

// File: rtl/alu_self_test_alu.sv
// 16-bit ALU with a registered {y, c} output; carry is the borrow for SUB.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             c
);

    logic [WIDTH:0]   res_c;
    logic [WIDTH-1:0] y_q = '0;
    logic             c_q = 1'b0;

    // Combinational result with carry/borrow in the top bit.
    always_comb begin
        res_c = '0;
        case (op)
            OP_ADD:    res_c = {1'b0, a} + {1'b0, b};
            OP_SUB:    res_c = {1'b0, a} - {1'b0, b};
            OP_AND:    res_c = {1'b0, a & b};
            OP_OR:     res_c = {1'b0, a | b};
            OP_XOR:    res_c = {1'b0, a ^ b};
            OP_SHL:    res_c = {1'b0, a << b[3:0]};
            OP_SHR:    res_c = {1'b0, a >> b[3:0]};
            OP_PASS_B: res_c = {1'b0, b};
            default:   res_c = '0;
        endcase
    end

    // Output register.
    always_ff @(posedge clk) begin
        y_q <= res_c[WIDTH-1:0];
        c_q <= res_c[WIDTH];
    end

    assign y = y_q;
    assign c = c_q;

endmodule

// File: rtl/alu_self_test.sv
// Self-test harness: walks the vector ROM through the ALU and flags mismatches.
module alu_self_test
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_self_test_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q      = ST_RUN;
    state_t           state_d;
    logic [IDX_W-1:0] index_q      = '0;
    logic [IDX_W-1:0] index_d;
    logic             cmp_valid_q  = 1'b0;
    logic             cmp_valid_d;
    logic             done_q       = 1'b0;
    logic             done_d;
    logic             result_q     = 1'b0;
    logic [IDX_W-1:0] fail_index_q = '0;
    logic [WIDTH-1:0] exp_y_q      = '0;
    logic             exp_c_q      = 1'b0;
    logic [IDX_W-1:0] exp_index_q  = '0;

    alu_vec_t         vec_c;
    logic [WIDTH-1:0] alu_a_c;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             mismatch_c;

    // Vector ROM indexed by the sequencer.
    always_comb begin
        vec_c = '0;
        case (index_q)
            4'd0:  vec_c = '{OP_ADD,    16'h0001, 16'h0001, 16'h0002, 1'b0};
            4'd1:  vec_c = '{OP_ADD,    16'hFFFF, 16'h0001, 16'h0000, 1'b1};
            4'd2:  vec_c = '{OP_ADD,    16'h8000, 16'h8000, 16'h0000, 1'b1};
            4'd3:  vec_c = '{OP_SUB,    16'h0005, 16'h0003, 16'h0002, 1'b0};
            4'd4:  vec_c = '{OP_SUB,    16'h0000, 16'h0001, 16'hFFFF, 1'b1};
            4'd5:  vec_c = '{OP_AND,    16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
            4'd6:  vec_c = '{OP_OR,     16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0};
            4'd7:  vec_c = '{OP_XOR,    16'hAAAA, 16'hFFFF, 16'h5555, 1'b0};
            4'd8:  vec_c = '{OP_SHL,    16'h0001, 16'h000F, 16'h8000, 1'b0};
            4'd9:  vec_c = '{OP_SHR,    16'h8000, 16'h000F, 16'h0001, 1'b0};
            4'd10: vec_c = '{OP_SHL,    16'h1234, 16'h0000, 16'h1234, 1'b0};
            4'd11: vec_c = '{OP_SHR,    16'h1234, 16'h0004, 16'h0123, 1'b0};
            4'd12: vec_c = '{OP_PASS_B, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};
            4'd13: vec_c = '{OP_ADD,    16'h1234, 16'h4321, 16'h5555, 1'b0};
            4'd14: vec_c = '{OP_XOR,    16'h1234, 16'h1234, 16'h0000, 1'b0};
            4'd15: vec_c = '{OP_SUB,    16'h8000, 16'h0001, 16'h7FFF, 1'b0};
            default: vec_c = '0;
        endcase
    end

    // Error injection flips operand A bit 0 for vectors applied while forced.
    assign alu_a_c = vec_c.a ^ WIDTH'(bus.force_error);

    alu u_alu (
        .clk (clk),
        .op  (vec_c.op),
        .a   (alu_a_c),
        .b   (vec_c.b),
        .y   (alu_y),
        .c   (alu_c)
    );

    // Sequencer next-state: apply every vector, drain the last compare, then hold.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cmp_valid_d = 1'b0;
        done_d      = done_q;
        case (state_q)
            ST_RUN: begin
                cmp_valid_d = 1'b1;
                if (index_q == IDX_W'(NUM_VECTORS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    index_d = index_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            index_q     <= '0;
            cmp_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cmp_valid_q <= cmp_valid_d;
            done_q      <= done_d;
        end
    end

    // Expected result travels one stage alongside the ALU register.
    always_ff @(posedge clk) begin
        exp_y_q     <= vec_c.y;
        exp_c_q     <= vec_c.c;
        exp_index_q <= index_q;
    end

    assign mismatch_c = cmp_valid_q && ({alu_y, alu_c} != {exp_y_q, exp_c_q});

    // Sticky fail flag; index captured only on the first mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q     <= 1'b0;
            fail_index_q <= '0;
        end else if (mismatch_c) begin
            result_q <= 1'b1;
            if (!result_q) begin
                fail_index_q <= exp_index_q;
            end
        end
    end

    assign bus.result_out = result_q;
    assign bus.done       = done_q;
    assign bus.fail_index = fail_index_q;

endmodule

// File: tb/tb_alu_self_test.sv
// Bench for alu_self_test: random error-injection masks against a vector-level model.
module tb_alu_self_test;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_self_test_if bus ();

    alu_self_test u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int rom_op [16] = '{0, 0, 0, 1, 1, 2, 3, 4, 5, 6, 5, 6, 7, 0, 4, 1};
    int rom_a  [16] = '{'h0001, 'hFFFF, 'h8000, 'h0005, 'h0000, 'hF0F0, 'hF0F0, 'hAAAA,
                        'h0001, 'h8000, 'h1234, 'h1234, 'h0000, 'h1234, 'h1234, 'h8000};
    int rom_b  [16] = '{'h0001, 'h0001, 'h8000, 'h0003, 'h0001, 'hFF00, 'h0F0F, 'hFFFF,
                        'h000F, 'h000F, 'h0000, 'h0004, 'hBEEF, 'h4321, 'h1234, 'h0001};
    int rom_y  [16] = '{'h0002, 'h0000, 'h0000, 'h0002, 'hFFFF, 'hF000, 'hFFFF, 'h5555,
                        'h8000, 'h0001, 'h1234, 'h0123, 'hBEEF, 'h5555, 'h0000, 'h7FFF};
    int rom_c  [16] = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reference ALU: returns carry in bit 16, result in bits 15:0.
    function automatic int ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: begin
                r = (a - b) & 'hFFFF;
                if (a < b) r = r + 'h10000;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a << (b % 16)) & 'hFFFF;
            6: r = a >> (b % 16);
            default: r = b;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One full pass: optional reset edge, then edges 1..20 with per-edge checks.
    // abort_at != 0 raises rst so that edge abort_at is a mid-run reset.
    task automatic run_seq(input logic [15:0] fmask, input bit do_reset, input int abort_at);
        bit mis [16];
        int exp_res;
        int exp_idx;
        for (int k = 0; k < 16; k++) begin
            mis[k] = ref_alu(rom_op[k], rom_a[k] ^ int'(fmask[k]), rom_b[k])
                     != ((rom_c[k] << 16) | rom_y[k]);
        end
        if (do_reset) begin
            rst = 1'b1;
            bus.force_error = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("rst_done", int'(bus.done), 0);
            check("rst_result", int'(bus.result_out), 0);
            check("rst_fail_index", int'(bus.fail_index), 0);
            rst = 1'b0;
        end
        bus.force_error = fmask[0];
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (abort_at == n) begin
                check("midrst_done", int'(bus.done), 0);
                check("midrst_result", int'(bus.result_out), 0);
                check("midrst_fail_index", int'(bus.fail_index), 0);
                return;
            end
            exp_res = 0;
            exp_idx = 0;
            for (int k = 0; k < 16; k++) begin
                if (k <= n - 2 && mis[k] && exp_res == 0) begin
                    exp_res = 1;
                    exp_idx = k;
                end
            end
            check($sformatf("done_e%0d", n), int'(bus.done), (n >= 17) ? 1 : 0);
            check($sformatf("result_e%0d", n), int'(bus.result_out), exp_res);
            check($sformatf("fail_index_e%0d", n), int'(bus.fail_index), exp_idx);
            if (n < 16) bus.force_error = fmask[n];
            else bus.force_error = 1'($urandom_range(0, 1));
            if (abort_at == n + 1) rst = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] m;
        bus.force_error = 1'b0;
        #1;
        check("pre_edge1_done", int'(bus.done), 0);
        check("pre_edge1_result", int'(bus.result_out), 0);
        // Power-up with rst never asserted.
        run_seq(16'h0000, 1'b0, 0);
        // Clean run after reset.
        run_seq(16'h0000, 1'b1, 0);
        // Error forced throughout: first miss is vector 0.
        run_seq(16'hFFFF, 1'b1, 0);
        // Error forced only on vector 7.
        run_seq(16'h0080, 1'b1, 0);
        // Random sparse injection masks.
        for (int i = 0; i < 6; i++) begin
            m = 16'($urandom & $urandom & $urandom);
            run_seq(m, 1'b1, 0);
        end
        // Mid-run reset at edge 10 after random injection, then clean rerun.
        m = 16'($urandom);
        run_seq(m, 1'b1, 10);
        run_seq(16'h0000, 1'b1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_self_test.md
# alu_self_test

Self-checking ALU harness: owns one 16-bit ALU instance, drives it from a fixed 16-entry vector ROM, compares every registered ALU result against the expected value, and reports a sticky fail flag plus a completion flag. The simulation top ORs `result_out` and ANDs `done` across all harnesses (ALU, CPU) to end simulation and report pass/fail.

## Interface
- `WIDTH`, 16: ALU data width.
- `NUM_VECTORS`, 16: ROM depth; index width is clog2(NUM_VECTORS).
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `force_error`  in  1: when high, bit 0 of operand A is inverted before the ALU; tied 0 in normal runs.
- `result_out`  out  1: sticky mismatch flag (0 = pass).
- `done`  out  1: sticky, high once the last vector has been compared.
- `fail_index`  out  4: index of the first mismatching vector; 0 if none.

## Operation
- ALU ops (3-bit): 0 ADD, 1 SUB (A−B, carry = borrow), 2 AND, 3 OR, 4 XOR, 5 SHL (A << B[3:0]), 6 SHR logical (A >> B[3:0]), 7 PASS_B. Carry is 0 for ops 2–7.
- ALU output is registered: `{y, c}` is captured one edge after the operands are applied.
- ROM, entries 0–15, given as op A,B -> y c:
  - 0: ADD 0001,0001 -> 0002 0
  - 1: ADD FFFF,0001 -> 0000 1
  - 2: ADD 8000,8000 -> 0000 1
  - 3: SUB 0005,0003 -> 0002 0
  - 4: SUB 0000,0001 -> FFFF 1
  - 5: AND F0F0,FF00 -> F000 0
  - 6: OR F0F0,0F0F -> FFFF 0
  - 7: XOR AAAA,FFFF -> 5555 0
  - 8: SHL 0001,000F -> 8000 0
  - 9: SHR 8000,000F -> 0001 0
  - 10: SHL 1234,0000 -> 1234 0
  - 11: SHR 1234,0004 -> 0123 0
  - 12: PASS_B 0000,BEEF -> BEEF 0
  - 13: ADD 1234,4321 -> 5555 0
  - 14: XOR 1234,1234 -> 0000 0
  - 15: SUB 8000,0001 -> 7FFF 0
- Sequencer states: RUN (index 0..15 applied) -> DRAIN (final compare) -> DONE (holds; index stops; no further compares).
- Compare: expected `{y, c}` is delayed one cycle alongside the ALU pipeline. On mismatch, `result_out` is set to 1; `fail_index` latches only on the first mismatch.
- Reset values: `result_out` 0, `done` 0, `fail_index` 0, index 0, state RUN, compare-valid 0.
- All state registers carry declaration initial values equal to their reset values, so the block also runs correctly with `rst` tied low.

## Timing
- Edge n (n = 1..16, counted after `rst` is low) captures the ALU result of vector n−1.
- Edge n+1 compares vector n−1; compares occur on edges 2..17.
- `done` and the final `result_out` update together on edge 17, and then hold until reset.
- `rst` asserted mid-run, on the same edge: clears all flags, returns index to 0, and invalidates the in-flight compare. The sequence restarts on the first edge after `rst` falls.
- `force_error` is sampled at operand-apply time and affects only vectors applied while it is high.

## Structure
- Package `alu_pkg`: `WIDTH`, the op enum `alu_op_t`, and the vector struct `{op, a, b, y, c}`.
- Sub-module `alu`: op, a, b in; registered y and c out. Reused by the CPU datapath.
- The harness holds the ROM (case on index), sequencer, compare pipeline and flags.

## Test plan
- Normal run, `force_error`=0 -> `done` rises at edge 17, `result_out`=0, `fail_index`=0.
- Before edge 1 and during reset -> `done`=0, `result_out`=0.
- `force_error`=1 for the whole run -> `result_out` goes to 1 at edge 2, `fail_index`=0, `done` still rises at edge 17.
- `force_error` pulsed only while vector 7 is applied (AAAB^FFFF=5554) -> `result_out`=1 at edge 9, `fail_index`=7.
- `rst` pulsed at edge 10, then released -> flags clear; `done` at 17 edges after release, `result_out`=0.
- `rst` tied low from power-up -> identical pass outcome.
